// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multi-cycle Moore control unit for the rv32i core.
// Sequences fetch/decode/execute/memory/writeback over shared datapath resources.
module uc_multiciclo #(
  parameter int ALU_CTRL_W  = 3,
  parameter int FULL_BRANCH = 0,
  parameter int MEM_WAIT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            f3,
  input  logic                  f7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  memReady,
  output logic                  pcWrite,
  output logic                  adrSrc,
  output logic                  irWrite,
  output logic                  memWrite,
  output logic                  regWrite,
  output logic [1:0]            resSrc,
  output logic [1:0]            aluSrcA,
  output logic [1:0]            aluSrcB,
  output logic [2:0]            immSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  illegal,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6,  S_EXECI   = 4'd7,
    S_ALUWB    = 4'd8,  S_JAL    = 4'd9,  S_JALR   = 4'd10, S_JALWB   = 4'd11,
    S_LUI      = 4'd12, S_BRANCH = 4'd13, S_TRAP   = 4'd14
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8, ALU_SRA = 4'd9;

  state_t cur, dispatch;
  logic   illegal_q;
  logic   ready, alu_ok, br_ok, taken;
  logic   pc_w, ir_w, mem_w, reg_w;
  logic   [ALU_CTRL_W-1:0] alu_fn;

  assign ready = (MEM_WAIT == 0) ? 1'b1 : memReady;

  // The base ALU has no shifter, xor or sltu, so those funct3 values cannot execute.
  assign alu_ok = (ALU_CTRL_W >= 4) ||
                  !((f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101) || (f3 == 3'b011));
  assign br_ok  = (FULL_BRANCH != 0) || (f3 == 3'b000);

  always_comb begin
    dispatch = S_TRAP;
    case (op)
      7'b0000011, 7'b0100011: dispatch = S_MEMADR;
      7'b0110011:             dispatch = alu_ok ? S_EXECR : S_TRAP;
      7'b0010011:             dispatch = alu_ok ? S_EXECI : S_TRAP;
      7'b1101111:             dispatch = S_JAL;
      7'b1100111:             dispatch = S_JALR;
      7'b0110111:             dispatch = S_LUI;
      7'b1100011:             dispatch = br_ok ? S_BRANCH : S_TRAP;
      default:                dispatch = S_TRAP;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  // f7 only distinguishes sub in R-type; shifts use it in both R and I forms.
  always_comb begin
    case (f3)
      3'b000:  alu_fn = ALU_CTRL_W'((cur == S_EXECR && f7) ? ALU_SUB : ALU_ADD);
      3'b001:  alu_fn = ALU_CTRL_W'(ALU_SLL);
      3'b010:  alu_fn = ALU_CTRL_W'(ALU_SLT);
      3'b011:  alu_fn = ALU_CTRL_W'(ALU_SLTU);
      3'b100:  alu_fn = ALU_CTRL_W'(ALU_XOR);
      3'b101:  alu_fn = ALU_CTRL_W'(f7 ? ALU_SRA : ALU_SRL);
      3'b110:  alu_fn = ALU_CTRL_W'(ALU_OR);
      default: alu_fn = ALU_CTRL_W'(ALU_AND);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (cur)
        S_FETCH:    if (ready) cur <= S_DECODE;
        S_DECODE: begin
          cur <= dispatch;
          if (dispatch == S_TRAP) illegal_q <= 1'b1;
        end
        S_MEMADR:   cur <= op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (ready) cur <= S_MEMWB;
        S_MEMWRITE: if (ready) cur <= S_FETCH;
        S_EXECR, S_EXECI, S_LUI:              cur <= S_ALUWB;
        S_JAL, S_JALR:                        cur <= S_JALWB;
        S_MEMWB, S_ALUWB, S_JALWB, S_BRANCH:  cur <= S_FETCH;
        S_TRAP:     cur <= S_TRAP;
        default:    cur <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    pc_w = 1'b0; ir_w = 1'b0; mem_w = 1'b0; reg_w = 1'b0;
    adrSrc = 1'b0; resSrc = 2'b00; aluSrcA = 2'b00; aluSrcB = 2'b00; immSrc = 3'b000;
    ALUControl = ALU_CTRL_W'(ALU_ADD);
    case (cur)
      S_FETCH:    begin aluSrcB = 2'b10; resSrc = 2'b10; ir_w = ready; pc_w = ready; end
      S_DECODE:   begin aluSrcA = 2'b01; aluSrcB = 2'b01; immSrc = 3'b010; end
      S_MEMADR:   begin aluSrcA = 2'b10; aluSrcB = 2'b01; immSrc = op[5] ? 3'b001 : 3'b000; end
      S_MEMREAD:  adrSrc = 1'b1;
      S_MEMWB:    begin resSrc = 2'b01; reg_w = 1'b1; end
      S_MEMWRITE: begin adrSrc = 1'b1; mem_w = 1'b1; end
      S_EXECR:    begin aluSrcA = 2'b10; ALUControl = alu_fn; end
      S_EXECI:    begin aluSrcA = 2'b10; aluSrcB = 2'b01; ALUControl = alu_fn; end
      S_ALUWB:    reg_w = 1'b1;
      S_JAL:      pc_w = 1'b1;
      S_JALR:     begin aluSrcA = 2'b10; aluSrcB = 2'b01; resSrc = 2'b10; pc_w = 1'b1; end
      S_JALWB:    begin aluSrcA = 2'b01; aluSrcB = 2'b10; resSrc = 2'b10; reg_w = 1'b1; end
      S_LUI:      begin aluSrcA = 2'b11; aluSrcB = 2'b01; immSrc = 3'b100; end
      S_BRANCH:   begin aluSrcA = 2'b10; ALUControl = ALU_CTRL_W'(ALU_SUB); pc_w = taken; end
      default:    ;
    endcase
  end

  // Write enables are masked by reset so nothing commits while rst_n is low.
  assign pcWrite  = pc_w  & rst_n;
  assign irWrite  = ir_w  & rst_n;
  assign memWrite = mem_w & rst_n;
  assign regWrite = reg_w & rst_n;
  assign illegal  = illegal_q;
  assign state    = cur;

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: directed bench for uc_multiciclo, one instance per parameter set.
module tb_uc_multiciclo;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [6:0] op;
  logic [2:0] f3;
  logic f7, zero, lt, ltu, memReady;

  logic pw_a, as_a, iw_a, mw_a, rw_a, ill_a;
  logic [1:0] rs_a, sa_a, sb_a;
  logic [2:0] is_a;
  logic [3:0] alu_a, st_a;
  logic pw_b, as_b, iw_b, mw_b, rw_b, ill_b;
  logic [1:0] rs_b, sa_b, sb_b;
  logic [2:0] is_b, alu_b;
  logic [3:0] st_b;

  logic [22:0] obs_a, obs_b;
  logic [22:0] sb[$];
  bit sel;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uc_multiciclo #(.ALU_CTRL_W(4), .FULL_BRANCH(1), .MEM_WAIT(1)) dut_a (
    .clk(clk), .rst_n(rst_a), .op(op), .f3(f3), .f7(f7), .zero(zero), .lt(lt), .ltu(ltu),
    .memReady(memReady), .pcWrite(pw_a), .adrSrc(as_a), .irWrite(iw_a), .memWrite(mw_a),
    .regWrite(rw_a), .resSrc(rs_a), .aluSrcA(sa_a), .aluSrcB(sb_a), .immSrc(is_a),
    .ALUControl(alu_a), .illegal(ill_a), .state(st_a));

  uc_multiciclo #(.ALU_CTRL_W(3), .FULL_BRANCH(0), .MEM_WAIT(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .op(op), .f3(f3), .f7(f7), .zero(zero), .lt(lt), .ltu(ltu),
    .memReady(memReady), .pcWrite(pw_b), .adrSrc(as_b), .irWrite(iw_b), .memWrite(mw_b),
    .regWrite(rw_b), .resSrc(rs_b), .aluSrcA(sa_b), .aluSrcB(sb_b), .immSrc(is_b),
    .ALUControl(alu_b), .illegal(ill_b), .state(st_b));

  assign obs_a = {st_a, pw_a, as_a, iw_a, mw_a, rw_a, rs_a, sa_a, sb_a, is_a, alu_a, ill_a};
  assign obs_b = {st_b, pw_b, as_b, iw_b, mw_b, rw_b, rs_b, sa_b, sb_b, is_b, 1'b0, alu_b, ill_b};

  function automatic logic [22:0] e(input int st, input bit pw, input bit as, input bit iw,
                                    input bit mw, input bit rw, input int rs, input int sa,
                                    input int sbv, input int is, input int alu, input bit ill);
    return {st[3:0], pw, as, iw, mw, rw, rs[1:0], sa[1:0], sbv[1:0], is[2:0], alu[3:0], ill};
  endfunction

  // One cycle: queue the expectation, sample mid-cycle, then advance to the next cycle.
  task automatic chk(input string tag, input logic [22:0] ex);
    logic [22:0] obs, want;
    sb.push_back(ex);
    #1;
    obs  = sel ? obs_b : obs_a;
    want = sb.pop_front();
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] fn3, input logic fn7);
    op = o; f3 = fn3; f7 = fn7;
  endtask

  logic [22:0] v_rst, v_fetch, v_dec, v_aluwb;

  initial begin
    v_rst   = e(0, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0);
    v_fetch = e(0, 1, 0, 1, 0, 0, 2, 0, 2, 0, 0, 0);
    v_dec   = e(1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
    v_aluwb = e(8, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    rst_a = 1'b0; rst_b = 1'b0; memReady = 1'b1;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; sel = 1'b0;
    instr(7'b0000011, 3'b010, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("reset_hold", v_rst);

    // lw with two wait cycles in MEMREAD
    rst_a = 1'b1;
    chk("lw_fetch", v_fetch);
    chk("lw_decode", v_dec);
    chk("lw_memadr", e(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    memReady = 1'b0;
    chk("lw_wait1", e(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("lw_wait2", e(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    memReady = 1'b1;
    chk("lw_memread", e(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("lw_memwb", e(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));

    // sw aborted by reset while waiting in MEMWRITE
    instr(7'b0100011, 3'b010, 1'b0);
    chk("sw_fetch", v_fetch);
    chk("sw_decode", v_dec);
    memReady = 1'b0;
    chk("sw_memadr", e(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0));
    chk("sw_wait", e(5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("sw_wait2", e(5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rst_a = 1'b0;
    chk("rst_async", v_rst);
    rst_a = 1'b1; memReady = 1'b1;

    // bne taken, bltu not taken
    instr(7'b1100011, 3'b001, 1'b0); zero = 1'b0;
    chk("bne_fetch", v_fetch);
    chk("bne_decode", v_dec);
    chk("bne_taken", e(13, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0));
    instr(7'b1100011, 3'b110, 1'b0); ltu = 1'b0;
    chk("bltu_fetch", v_fetch);
    chk("bltu_decode", v_dec);
    chk("bltu_not_taken", e(13, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0));

    instr(7'b1100111, 3'b000, 1'b0);
    chk("jalr_fetch", v_fetch);
    chk("jalr_decode", v_dec);
    chk("jalr_exec", e(10, 1, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0));
    chk("jalr_wb", e(11, 0, 0, 0, 0, 1, 2, 1, 2, 0, 0, 0));

    instr(7'b0010011, 3'b101, 1'b1);
    chk("srai_fetch", v_fetch);
    chk("srai_decode", v_dec);
    chk("srai_exec", e(7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 9, 0));
    chk("srai_wb", v_aluwb);

    instr(7'b0010011, 3'b000, 1'b1);
    chk("addi_fetch", v_fetch);
    chk("addi_decode", v_dec);
    chk("addi_f7_ignored", e(7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    chk("addi_wb", v_aluwb);

    instr(7'b0110011, 3'b000, 1'b1);
    chk("sub_fetch", v_fetch);
    chk("sub_decode", v_dec);
    chk("sub_exec", e(6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0));
    chk("sub_wb", v_aluwb);

    instr(7'b0110111, 3'b000, 1'b0);
    chk("lui_fetch", v_fetch);
    chk("lui_decode", v_dec);
    chk("lui_exec", e(12, 0, 0, 0, 0, 0, 0, 3, 1, 4, 0, 0));
    chk("lui_wb", v_aluwb);

    // Base configuration: memReady ignored, xor and bne trap
    rst_a = 1'b0; sel = 1'b1; rst_b = 1'b1; memReady = 1'b0;
    instr(7'b0110011, 3'b100, 1'b0);
    chk("b_fetch_noready", v_fetch);
    chk("b_xor_decode", v_dec);
    memReady = 1'b1;
    chk("b_xor_trap", e(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("b_trap_sticky1", e(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("b_trap_sticky2", e(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    rst_b = 1'b0;
    chk("b_trap_reset", v_rst);
    rst_b = 1'b1;
    instr(7'b1100011, 3'b001, 1'b0);
    chk("b_bne_fetch", v_fetch);
    chk("b_bne_decode", v_dec);
    chk("b_bne_trap", e(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    rst_b = 1'b0;
    chk("b_reset2", v_rst);
    rst_b = 1'b1; memReady = 1'b0; zero = 1'b1;
    instr(7'b1100011, 3'b000, 1'b0);
    chk("b_beq_fetch", v_fetch);
    chk("b_beq_decode", v_dec);
    chk("b_beq_taken", e(13, 1, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0));
    chk("b_beq_next", v_fetch);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uc_multiciclo.md
# uc_multiciclo

Multi-cycle control unit for the rv32i core. It replaces the single-cycle decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several clocks, so datapath resources are shared. Parameters select:
- ALU control width (base or extended op set),
- full conditional-branch support,
- a memory ready handshake.

## Interface
Parameters:
- ALU_CTRL_W, 3: ALUControl width; 3 = add/sub/and/or/slt, 4 adds xor/sltu/sll/srl/sra.
- FULL_BRANCH, 0: 0 = beq only; 1 = beq/bne/blt/bge/bltu/bgeu.
- MEM_WAIT, 0: 1 = FETCH/MEMREAD/MEMWRITE hold until memReady; 0 = memReady ignored (treated as 1).

Ports (clock and reset first):
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- op  in  7  instr[6:0].
- f3  in  3  instr[14:12].
- f7  in  1  instr[30].
- zero, lt, ltu  in  1 each  ALU flags of the current rs1−rs2.
- memReady  in  1  memory completed the access this cycle.
- pcWrite  out  1  PC register enable.
- adrSrc  out  1  0 = PC, 1 = ALUOut as memory address.
- irWrite  out  1  instruction/oldPC register enable.
- memWrite  out  1  store strobe.
- regWrite  out  1  register file write.
- resSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- aluSrcA  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero.
- aluSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
- immSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUControl  out  ALU_CTRL_W  ALU operation.
- illegal  out  1  sticky; set on TRAP entry.
- state  out  4  current state code, for debug.

## Operation
States and transitions:
- FETCH(0): adrSrc=0, aluSrcA=00, aluSrcB=10, add, resSrc=10. When ready: irWrite=1, pcWrite=1, go to DECODE. Otherwise stay with all enables 0.
- DECODE(1): aluSrcA=01, aluSrcB=01, add, immSrc=B (oldPC+imm → ALUOut).
- DECODE dispatch by op:
  - 0000011 or 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1101111 → JAL.
  - 1100111 → JALR.
  - 0110111 → LUI.
  - 1100011 → BRANCH.
  - any other → TRAP.
- MEMADR(2): rs1+imm; immSrc I for loads, S for stores. Loads → MEMREAD, stores → MEMWRITE.
- MEMREAD(3): adrSrc=1. When ready → MEMWB.
- MEMWB(4): resSrc=01, regWrite=1 → FETCH.
- MEMWRITE(5): adrSrc=1, memWrite=1 held until ready → FETCH.
- EXECR(6): rs1 op rs2 → ALUWB.
- EXECI(7): rs1 op imm (I) → ALUWB.
- ALUWB(8): resSrc=00, regWrite=1 → FETCH.
- JAL(9): resSrc=00, pcWrite=1 → JALWB.
- JALR(10): rs1+imm(I), resSrc=10, pcWrite=1 → JALWB.
- JALWB(11): oldPC+4, resSrc=10, regWrite=1 → FETCH.
- LUI(12): zero+imm(U) → ALUWB.
- BRANCH(13): rs1−rs2, resSrc=00, pcWrite=taken → FETCH.
- TRAP(14): all enables 0; illegal=1; stays until reset.

Branch conditions (taken):
- beq: zero. bne: !zero.
- blt: lt. bge: !lt.
- bltu: ltu. bgeu: !ltu.
- FULL_BRANCH=0: any f3≠000 → TRAP at DECODE.

ALU decode:
- Base codes: add 000, sub 001, and 010, or 011, slt 101.
- ALU_CTRL_W=4 extends with: xor 0100, sltu 0110, sll 0111, srl 1000, sra 1001. Base codes are zero-extended to 4 bits.
- R-type: sub when f7=1; srl/sra selected by f7.
- I-type: f7 selects sra only for f3=101; otherwise f7 is ignored (so addi never becomes sub).
- f3 ∈ {001, 100, 101, 011} with ALU_CTRL_W=3 → TRAP at DECODE.

Unused select outputs are 0 in every state.

## Timing
- Reset: asynchronous entry to FETCH. While rst_n=0, pcWrite, irWrite, memWrite and regWrite are forced 0, and illegal=0.
- Outputs are Moore (state-decoded), except:
  - the memReady gating in FETCH/MEMREAD/MEMWRITE;
  - the branch-taken term of pcWrite.
- Cycles per instruction with zero wait: lw 5; sw, R, I, jal, jalr, lui 4; branch 3.
- Each cycle of memReady=0 adds exactly one cycle. memWrite stays high through the whole wait.
- Reset mid-instruction aborts it; no write enable is asserted after rst_n falls.
- The first FETCH is at the first rising edge after rst_n rises.

## Test plan
- Reset with rst_n=0 during MEMWRITE → state=0, memWrite=0 immediately (asynchronously); after release, irWrite=1 on the first edge.
- lw (op 0000011), MEM_WAIT=1, memReady low 2 cycles in MEMREAD → state sequence 0,1,2,3,3,3,4,0; regWrite=1 only in state 4 with resSrc=01.
- FULL_BRANCH=1: bne with zero=0 → pcWrite=1 in BRANCH; bltu with ltu=0 → pcWrite=0; each takes 3 cycles.
- jalr → pcWrite with resSrc=10, aluSrcA=10, then JALWB with regWrite=1, aluSrcA=01, aluSrcB=10.
- ALU_CTRL_W=3, R-type f3=100 (xor) → TRAP, illegal=1 sticky; no enable asserted until reset.
- ALU_CTRL_W=4, I-type f3=101 f7=1 → ALUControl=1001; R-type f3=000 f7=1 → 0001.
